uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_fifo_ram.sv | 27 ++
 rtl/uart_rx_fifo.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and receive-queue defaults.
// The UART top and the receive FIFO both take their sizes from here.
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int UART_DEPTH  = 16;
    localparam int UART_AW     = 4;
    localparam int UART_ERR_W  = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage for the receive queue.
// Synchronous write, asynchronous read, so the head byte is visible without extra latency.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEPTH,
    parameter int AW    = UART_AW
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [UART_BYTE_W-1:0] i_wdata,
    input  logic [AW-1:0]          i_raddr,
    output logic [UART_BYTE_W-1:0] o_rdata
);

    uart_byte_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through queue between the UART receiver and its consumer.
// It drops bytes that carry an error or arrive while the queue is full, and counts receive errors.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEPTH,
    parameter int AW    = UART_AW,
    parameter int ERR_W = UART_ERR_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_received,
    input  logic [UART_BYTE_W-1:0] i_rx_byte,
    input  logic                   i_recv_error,
    output logic [UART_BYTE_W-1:0] o_rd_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    input  logic                   i_flush,
    input  logic                   i_clr_ovf,
    output logic [AW:0]            o_count,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic [ERR_W-1:0]       o_err_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_err_prev;

    logic       w_full;
    logic       w_rd_valid;
    logic       w_good_byte;
    logic       w_pop;
    logic       w_push;
    logic       w_drop_full;
    logic       w_err_rise;
    uart_byte_t w_ram_rdata;

    // Flags come only from registered occupancy; no path from i_received or i_rd_ready.
    assign w_full      = (r_count == FULL_CNT);
    assign w_rd_valid  = (r_count != '0);
    assign w_good_byte = i_received && !i_recv_error;
    assign w_pop       = w_rd_valid && i_rd_ready;
    assign w_push      = w_good_byte && (!w_full || w_pop);
    assign w_drop_full = w_good_byte && w_full && !w_pop;
    assign w_err_rise  = i_recv_error && !r_err_prev;

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_push && !i_flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_rx_byte),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    // DEPTH is a power of two, so the natural pointer rollover is the wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop_full) begin
            r_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_prev <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_err_prev <= i_recv_error;
            if (w_err_rise && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign o_rd_data  = w_ram_rdata;
    assign o_rd_valid = w_rd_valid;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;
    assign o_err_cnt  = r_err_cnt;

endmodule
